// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and sizing for the ALU issue unit.
package alu_pkg;

  localparam int DEF_REG_AW = 6;

  localparam logic [3:0] OP_OR  = 4'h0;
  localparam logic [3:0] OP_XOR = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SAR = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_MOD = 4'hB;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB,
      OP_MUL, OP_SHL, OP_SAR, OP_DIV, OP_MOD: is_legal_op = 1'b1;
      default:                                is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 64x32 integer register file: two operand read ports, a debug read port,
// and one write port where an instruction writeback beats a host preload.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int AW = DEF_REG_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr0,
  output logic [31:0]   rd_data0,
  input  logic [AW-1:0] rd_addr1,
  output logic [31:0]   rd_data1,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata
);

  localparam int NREG = 1 << AW;

  logic [31:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_we && wb_addr == AW'(i))
          regs[i] <= wb_data;
        else if (host_we && host_addr == AW'(i))
          regs[i] <= host_wdata;
      end
    end
  end

  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Sequential issuer for the combinational ALU: accepts an instruction, reads
// operands, waits EXEC_LAT cycles for the ALU, then writes the result back.
//
// state | meaning
// IDLE  | ready for an instruction
// READ  | register operands to the ALU inputs
// EXEC  | down-count EXEC_LAT cycles, then capture alu_dout
// WB    | write result to the register file, wb_valid pulse
// ERR   | illegal opcode rejected, err pulse
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int EXEC_LAT = 1,
  parameter int REG_AW   = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs0,
  input  logic [REG_AW-1:0] instr_rs1,
  output logic [31:0]       alu_d0,
  output logic [31:0]       alu_d1,
  output logic [3:0]        alu_op,
  input  logic [31:0]       alu_dout,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic              err,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        op_q;
  logic [REG_AW-1:0] rd_q, rs0_q, rs1_q;
  logic [31:0]       rs0_data, rs1_data;
  logic              accept;

  assign instr_ready = (state == IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign wb_valid    = (state == WB);
  assign err         = (state == ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rs0_q   <= '0;
      rs1_q   <= '0;
      alu_d0  <= '0;
      alu_d1  <= '0;
      alu_op  <= '0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs0_q <= instr_rs0;
        rs1_q <= instr_rs1;
      end
      case (state)
        READ: begin
          alu_d0 <= rs0_data;
          alu_d1 <= rs1_data;
          alu_op <= op_q;
          cnt    <= 4'(EXEC_LAT - 1);
        end
        EXEC: begin
          // Terminal count: the ALU output has had EXEC_LAT cycles to settle
          if (cnt == '0) begin
            wb_data <= alu_dout;
            wb_addr <= rd_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_legal_op(instr_op) ? READ : ERR;
      READ:    state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = WB;
      WB:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  alu_regfile #(.AW(REG_AW)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .rd_addr0   (rs0_q),
    .rd_data0   (rs0_data),
    .rd_addr1   (rs1_q),
    .rd_data1   (rs1_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .wb_we      (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata)
  );

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: an EXEC_LAT=1 and an EXEC_LAT=3 instance against a
// register-array reference model; a behavioural ALU closes the loop.
module tb_alu_issue_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        dsel = 1'b0;
  logic        instr_valid = 1'b0;
  logic [3:0]  instr_op = '0;
  logic [5:0]  instr_rd = '0, instr_rs0 = '0, instr_rs1 = '0;
  logic        host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [5:0]  dbg_addr = '0;

  logic        ready_a, ready_b, wbv_a, wbv_b, err_a, err_b;
  logic [31:0] d0_a, d0_b, d1_a, d1_b, dout_a, dout_b, wbd_a, wbd_b, dbg_a, dbg_b;
  logic [3:0]  op_a, op_b;
  logic [5:0]  wba_a, wba_b;

  logic        ready, wbv, err;
  logic [31:0] d0, d1, wbd, dbg;
  logic [3:0]  aop;
  logic [5:0]  wba;

  int checks = 0;
  int failures = 0;
  logic [31:0] rf [2][64];

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'h0: return a | b;
      4'h1: return a ^ b;
      4'h2: return a & b;
      4'h4: return a + b;
      4'h5: return a - b;
      4'h6: return a * b;
      4'h8: return a << sh;
      4'h9: return 32'($signed(a) >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] op);
    return !(op inside {4'h3, 4'h7, [4'hC:4'hF]});
  endfunction

  assign dout_a = alu_f(op_a, d0_a, d1_a);
  assign dout_b = alu_f(op_b, d0_b, d1_b);

  assign ready = dsel ? ready_b : ready_a;
  assign wbv   = dsel ? wbv_b   : wbv_a;
  assign err   = dsel ? err_b   : err_a;
  assign d0    = dsel ? d0_b    : d0_a;
  assign d1    = dsel ? d1_b    : d1_a;
  assign aop   = dsel ? op_b    : op_a;
  assign wba   = dsel ? wba_b   : wba_a;
  assign wbd   = dsel ? wbd_b   : wbd_a;
  assign dbg   = dsel ? dbg_b   : dbg_a;

  alu_issue_unit #(.EXEC_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid & ~dsel), .instr_ready(ready_a),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs0(instr_rs0), .instr_rs1(instr_rs1),
    .alu_d0(d0_a), .alu_d1(d1_a), .alu_op(op_a), .alu_dout(dout_a),
    .wb_valid(wbv_a), .wb_addr(wba_a), .wb_data(wbd_a), .err(err_a),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  alu_issue_unit #(.EXEC_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid & dsel), .instr_ready(ready_b),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs0(instr_rs0), .instr_rs1(instr_rs1),
    .alu_d0(d0_b), .alu_d1(d1_b), .alu_op(op_b), .alu_dout(dout_b),
    .wb_valid(wbv_b), .wb_addr(wba_b), .wb_data(wbd_b), .err(err_b),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  task automatic host_write(input logic [5:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk); @(negedge clk);
    host_we = 1'b0;
    rf[0][a] = d; rf[1][a] = d;
  endtask

  // Present an instruction; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [5:0] rd, input logic [5:0] rs0, input logic [5:0] rs1);
    int guard;
    guard = 0;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs0 = rs0; instr_rs1 = rs1;
    while (!ready && guard < 40) begin @(negedge clk); guard++; end
    if (guard >= 40) begin
      checks++; failures++;
      $display("FAIL issue_timeout ready=%b required=1", ready);
    end
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic exec_check(input logic [3:0] op, input logic [5:0] rd, input logic [5:0] rs0,
                            input logic [5:0] rs1, input int lat, input bit hw,
                            input logic [5:0] haddr, input logic [31:0] hdata);
    logic [31:0] exp;
    exp = alu_f(op, rf[dsel][rs0], rf[dsel][rs1]);
    @(negedge clk);
    checks++; if (d0 !== rf[dsel][rs0]) begin failures++; $display("FAIL alu_d0 got=%h exp=%h", d0, rf[dsel][rs0]); end
    checks++; if (d1 !== rf[dsel][rs1]) begin failures++; $display("FAIL alu_d1 got=%h exp=%h", d1, rf[dsel][rs1]); end
    checks++; if (aop !== op) begin failures++; $display("FAIL alu_op got=%h exp=%h", aop, op); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b exp=0", ready); end
    for (int i = 0; i < lat; i++) begin
      checks++; if (wbv !== 1'b0) begin failures++; $display("FAIL early_wb cyc=%0d got=%b exp=0", i, wbv); end
      @(negedge clk);
    end
    checks++; if (wbv !== 1'b1) begin failures++; $display("FAIL wb_valid got=%b exp=1", wbv); end
    checks++; if (wba !== rd) begin failures++; $display("FAIL wb_addr got=%h exp=%h", wba, rd); end
    checks++; if (wbd !== exp) begin failures++; $display("FAIL wb_data got=%h exp=%h", wbd, exp); end
    if (hw) begin host_we = 1'b1; host_addr = haddr; host_wdata = hdata; end
    @(negedge clk);
    host_we = 1'b0;
    if (hw) begin rf[0][haddr] = hdata; rf[1][haddr] = hdata; end
    rf[dsel][rd] = exp;
    checks++; if (wbv !== 1'b0) begin failures++; $display("FAIL wb_pulse_len got=%b exp=0", wbv); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ready_after_wb got=%b exp=1", ready); end
    dbg_addr = rd; #1;
    checks++; if (dbg !== rf[dsel][rd]) begin failures++; $display("FAIL dbg_rd got=%h exp=%h", dbg, rf[dsel][rd]); end
    if (hw) begin
      dbg_addr = haddr; #1;
      checks++; if (dbg !== rf[dsel][haddr]) begin failures++; $display("FAIL dbg_host got=%h exp=%h", dbg, rf[dsel][haddr]); end
    end
  endtask

  task automatic err_check(input logic [5:0] rd);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", err); end
    checks++; if (wbv !== 1'b0) begin failures++; $display("FAIL err_no_wb got=%b exp=0", wbv); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL err_ready got=%b exp=0", ready); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_len got=%b exp=0", err); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL err_ready_back got=%b exp=1", ready); end
    dbg_addr = rd; #1;
    checks++; if (dbg !== rf[dsel][rd]) begin failures++; $display("FAIL err_rd_kept got=%h exp=%h", dbg, rf[dsel][rd]); end
  endtask

  task automatic run(input logic [3:0] op, input logic [5:0] rd, input logic [5:0] rs0, input logic [5:0] rs1);
    issue(op, rd, rs0, rs1);
    if (legal(op)) exec_check(op, rd, rs0, rs1, dsel ? 3 : 1, 1'b0, 6'd0, 32'd0);
    else err_check(rd);
  endtask

  task automatic test_reset();
    logic [5:0] addrs [3];
    addrs[0] = 6'h00; addrs[1] = 6'h01; addrs[2] = 6'h3F;
    for (int i = 0; i < 64; i++) begin rf[0][i] = '0; rf[1][i] = '0; end
    @(negedge clk); @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ready_in_reset got=%b exp=0", ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", ready); end
    checks++; if (wbv !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", wbv, err); end
    foreach (addrs[i]) begin
      dbg_addr = addrs[i]; #1;
      checks++; if (dbg !== 32'h0) begin failures++; $display("FAIL reset_reg a=%h got=%h exp=0", addrs[i], dbg); end
    end
  endtask

  task automatic test_add();
    host_write(6'h01, 32'd3);
    host_write(6'h02, 32'd7);
    run(4'h4, 6'h03, 6'h01, 6'h02);
    dbg_addr = 6'h03; #1;
    checks++; if (dbg !== 32'h0000000A) begin failures++; $display("FAIL add_r03 got=%h exp=0000000A", dbg); end
  endtask

  task automatic test_back_to_back();
    int guard;
    guard = 0;
    instr_valid = 1'b1; instr_op = 4'h5; instr_rd = 6'h04; instr_rs0 = 6'h01; instr_rs1 = 6'h02;
    while (!ready && guard < 40) begin @(negedge clk); guard++; end
    @(posedge clk); @(negedge clk);
    // Second instruction held valid while the unit is busy
    instr_op = 4'h4; instr_rd = 6'h01; instr_rs0 = 6'h01; instr_rs1 = 6'h01;
    exec_check(4'h5, 6'h04, 6'h01, 6'h02, 1, 1'b0, 6'd0, 32'd0);
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    exec_check(4'h4, 6'h01, 6'h01, 6'h01, 1, 1'b0, 6'd0, 32'd0);
    dbg_addr = 6'h04; #1;
    checks++; if (dbg !== 32'hFFFFFFFC) begin failures++; $display("FAIL sub_r04 got=%h exp=FFFFFFFC", dbg); end
    dbg_addr = 6'h01; #1;
    checks++; if (dbg !== 32'h00000006) begin failures++; $display("FAIL self_add_r01 got=%h exp=00000006", dbg); end
  endtask

  task automatic test_illegal();
    run(4'h3, 6'h03, 6'h01, 6'h02);
    dbg_addr = 6'h03; #1;
    checks++; if (dbg !== 32'h0000000A) begin failures++; $display("FAIL illegal_r03 got=%h exp=0000000A", dbg); end
  endtask

  task automatic test_collision();
    // R01=6, R02=7 here
    issue(4'h4, 6'h05, 6'h01, 6'h02);
    exec_check(4'h4, 6'h05, 6'h01, 6'h02, 1, 1'b1, 6'h05, 32'hDEADBEEF);
    dbg_addr = 6'h05; #1;
    checks++; if (dbg !== 32'h0000000D) begin failures++; $display("FAIL wb_wins_r05 got=%h exp=0000000D", dbg); end
    issue(4'h0, 6'h05, 6'h01, 6'h02);
    exec_check(4'h0, 6'h05, 6'h01, 6'h02, 1, 1'b1, 6'h06, 32'hDEADBEEF);
    dbg_addr = 6'h06; #1;
    checks++; if (dbg !== 32'hDEADBEEF) begin failures++; $display("FAIL host_r06 got=%h exp=DEADBEEF", dbg); end
    dbg_addr = 6'h05; #1;
    checks++; if (dbg !== 32'h00000007) begin failures++; $display("FAIL or_r05 got=%h exp=00000007", dbg); end
  endtask

  task automatic test_lat3();
    dsel = 1'b1;
    run(4'h4, 6'h0A, 6'h01, 6'h02);
    run(4'h9, 6'h0B, 6'h06, 6'h02);
    dsel = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) host_write(6'(i), $urandom);
    for (int i = 0; i < 30; i++) begin
      dsel = ((i % 4) == 3);
      if ($urandom_range(0, 2) == 0) host_write(6'($urandom_range(0, 7)), $urandom);
      run(4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
    end
    dsel = 1'b0;
  endtask

  task automatic test_reset_mid();
    dsel = 1'b1;
    issue(4'h4, 6'h11, 6'h01, 6'h02);
    @(negedge clk); @(negedge clk);
    reset = 1'b1; #1;
    checks++; if (ready !== 1'b0 || wbv !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL mid_reset_outs got=%b%b%b exp=000", ready, wbv, err); end
    checks++; if (d0 !== 32'h0 || wbd !== 32'h0) begin failures++; $display("FAIL mid_reset_regs got=%h/%h exp=0", d0, wbd); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin rf[0][i] = '0; rf[1][i] = '0; end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (wbv_a | wbv_b | err_a | err_b) begin failures++; $display("FAIL post_reset_pulse cyc=%0d exp=none", i); end
    end
    checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b%b exp=11", ready_a, ready_b); end
    for (int i = 0; i < 64; i++) begin
      dbg_addr = 6'(i); #1;
      checks++; if (dbg_a !== 32'h0 || dbg_b !== 32'h0) begin
        failures++; $display("FAIL post_reset_reg a=%0d got=%h/%h exp=0", i, dbg_a, dbg_b); end
    end
    dsel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_collision();
    test_lat3();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
